// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES constants, S-box and Rcon lookups, key-schedule states
// Revision : 1.0
// ============================================================================
package aes_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int AES_MAX_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } ks_state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
// Module   : aes_sub_word
// Purpose  : Four parallel S-box lookups on a 32-bit word
// Revision : 1.0
// ============================================================================
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign o_word[gi*8 +: 8] = sbox(i_word[gi*8 +: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/aes_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_sched
// Purpose  : Sequential AES-128 key expansion, one round key per handshake
// Revision : 1.0
// ============================================================================
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int ROUNDS = 10
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AES_KEY_W-1:0] key_in,
    output logic                 busy,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [AES_KEY_W-1:0] rk_out,
    output logic [3:0]           rk_idx,
    output logic                 done
);

    localparam logic [3:0] c_LAST_IDX = 4'(ROUNDS);

    if (ROUNDS < 1 || ROUNDS > AES_MAX_ROUNDS) begin : g_bad_rounds
        $error("aes_key_sched: ROUNDS must be within 1..10");
    end

    ks_state_t              r_state;
    ks_state_t              w_state_nxt;
    logic [AES_KEY_W-1:0]   r_key;
    logic [3:0]             r_idx;
    logic                   w_load;
    logic                   w_advance;

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    // Next round key from the current one: RotWord/SubWord/Rcon, then a ripple XOR chain.
    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    aes_sub_word u_sub_word (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_t  = w_sub ^ rcon(r_idx + 4'd1);
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_EMIT;
                    w_load      = 1'b1;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
            r_idx <= 4'd0;
        end else if (w_load) begin
            r_key <= key_in;
            r_idx <= 4'd0;
        end else if (w_advance) begin
            r_key <= {w_n0, w_n1, w_n2, w_n3};
            r_idx <= r_idx + 4'd1;
        end
    end

    assign busy     = (r_state == ST_EMIT);
    assign rk_valid = (r_state == ST_EMIT);
    assign done     = (r_state == ST_DONE);
    assign rk_out   = r_key;
    assign rk_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_sched
// Purpose  : Self-checking bench for aes_key_sched against a FIPS-197 model
// Revision : 1.0
// ============================================================================
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, rk_ready, busy, rk_valid, done;
    logic [127:0] key_in, rk_out;
    logic [3:0]   rk_idx;
    logic         start1, ready1, busy1, valid1, done1;
    logic [127:0] key1, out1;
    logic [3:0]   idx1;

    always #5 clk = ~clk;

    aes_key_sched #(.ROUNDS(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx), .done(done)
    );

    aes_key_sched #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .key_in(key1), .busy(busy1),
        .rk_valid(valid1), .rk_ready(ready1), .rk_out(out1), .rk_idx(idx1), .done(done1)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [256];
    logic [7:0]   rc [11];
    logic [127:0] exp_rk [11];
    logic [127:0] got_key [16];
    int           got_idx [16];
    int           n_got;
    int           done_cyc;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [6];

    localparam logic [127:0] c_FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // S-box derived from GF(2^8) inversion plus the affine transform, not from a table.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rc[i] = gmul(rc[i-1], 8'h02);
    endtask

    // Textbook word-array key expansion.
    task automatic model_expand(input logic [127:0] key, input int rounds);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 4 * (rounds + 1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4], 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= rounds; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Drives one expansion on the ROUNDS=10 instance, collecting every transferred key.
    task automatic run_main(input logic [127:0] key, input bit stall,
                            input int inj_cyc, input logic [127:0] inj_key);
        logic [127:0] hold_key;
        logic [3:0]   hold_idx;
        bit           was_stalled;
        int           c;
        n_got = 0; done_cyc = -1; was_stalled = 1'b0;
        start = 1'b1; key_in = key; rk_ready = 1'b0;
        tick();
        start = 1'b0; key_in = ~key;
        chk("busy_after_start", 128'(busy), 128'(1'b1));
        c = 1;
        while (c < 400 && done_cyc < 0) begin
            if (done) begin
                done_cyc = c;
            end else begin
                if (was_stalled) begin
                    chk("stall_valid", 128'(rk_valid), 128'(1'b1));
                    chk("stall_key", rk_out, hold_key);
                    chk("stall_idx", 128'(rk_idx), 128'(hold_idx));
                end
                start  = (c == inj_cyc);
                key_in = (c == inj_cyc) ? inj_key : ~key;
                rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                was_stalled = rk_valid && !rk_ready;
                hold_key = rk_out;
                hold_idx = rk_idx;
                if (rk_valid && rk_ready && n_got < 16) begin
                    got_key[n_got] = rk_out;
                    got_idx[n_got] = int'(rk_idx);
                    n_got++;
                end
                tick();
                c++;
            end
        end
        rk_ready = 1'b0;
        chk("done_seen", 128'(done_cyc >= 0), 128'(1'b1));
        if (done_cyc >= 0) begin
            chk("done_busy", 128'(busy), 128'(1'b0));
            chk("done_valid", 128'(rk_valid), 128'(1'b0));
            start = 1'b1; key_in = inj_key;
            tick();
            start = 1'b0;
            chk("done_pulse_width", 128'(done), 128'(1'b0));
            chk("start_in_done_ignored", 128'(rk_valid | busy), 128'(1'b0));
        end
    endtask

    task automatic run_and_verify(input string tag, input logic [127:0] key, input bit stall,
                                  input int inj_cyc, input logic [127:0] inj_key);
        run_main(key, stall, inj_cyc, inj_key);
        model_expand(key, 10);
        chk($sformatf("%s_count", tag), 128'(n_got), 128'(11));
        for (int i = 0; i < n_got && i < 11; i++) begin
            chk($sformatf("%s_idx%0d", tag, i), 128'(got_idx[i]), 128'(i));
            chk($sformatf("%s_key%0d", tag, i), got_key[i], exp_rk[i]);
        end
        if (!stall) chk($sformatf("%s_done_cycle", tag), 128'(done_cyc), 128'(12));
    endtask

    initial begin
        logic [127:0] rk;
        int           guard;
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        start1 = 1'b0; ready1 = 1'b0; key1 = '0;
        build_tables();

        vecs[0] = '{key: c_FIPS_KEY, idx: 0,  exp: c_FIPS_KEY};
        vecs[1] = '{key: c_FIPS_KEY, idx: 1,  exp: 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{key: c_FIPS_KEY, idx: 2,  exp: 128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3] = '{key: c_FIPS_KEY, idx: 10, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4] = '{key: 128'h0,     idx: 1,  exp: 128'h62636363626363636263636362636363};
        vecs[5] = '{key: 128'h0,     idx: 10, exp: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        tick();
        tick();
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_valid", 128'(rk_valid), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_out", rk_out, 128'h0);
        chk("rst_idx", 128'(rk_idx), 128'(4'd0));
        rst_n = 1'b1;
        rk_ready = 1'b1;
        tick();
        chk("ready_in_idle", 128'(rk_valid), 128'(1'b0));

        for (int v = 0; v < 6; v++) begin
            run_and_verify($sformatf("vec%0d", v), vecs[v].key, 1'b0, -1, '0);
            if (vecs[v].idx < n_got) rk = got_key[vecs[v].idx];
            else rk = 'x;
            chk($sformatf("table%0d", v), rk, vecs[v].exp);
            tick();
        end

        run_and_verify("fips_stall", c_FIPS_KEY, 1'b1, -1, '0);
        run_and_verify("start_while_busy", c_FIPS_KEY, 1'b0, 4, 128'hdeadbeef_01234567_89abcdef_cafef00d);
        for (int r = 0; r < 4; r++) begin
            run_and_verify($sformatf("rand%0d", r), {$urandom, $urandom, $urandom, $urandom},
                           1'b1, (r == 1) ? 3 : -1, {$urandom, $urandom, $urandom, $urandom});
        end

        // Reset in the middle of an expansion.
        start = 1'b1; key_in = c_FIPS_KEY; rk_ready = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (rk_idx != 4'd5 && guard < 20) begin
            tick();
            guard++;
        end
        chk("reached_idx5", 128'(rk_idx), 128'(4'd5));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 128'(rk_valid), 128'(1'b0));
        chk("abort_busy", 128'(busy), 128'(1'b0));
        chk("abort_done", 128'(done), 128'(1'b0));
        chk("abort_out", rk_out, 128'h0);
        chk("abort_idx", 128'(rk_idx), 128'(4'd0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("no_done_after_abort", 128'(done | rk_valid), 128'(1'b0));
            tick();
        end
        run_and_verify("after_reset", {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, '0);

        // ROUNDS=1 instance: two keys then done.
        model_expand(c_FIPS_KEY, 1);
        start1 = 1'b1; key1 = c_FIPS_KEY;
        tick();
        start1 = 1'b0; key1 = '0; ready1 = 1'b1;
        chk("r1_valid0", 128'(valid1), 128'(1'b1));
        chk("r1_idx0", 128'(idx1), 128'(4'd0));
        chk("r1_key0", out1, exp_rk[0]);
        tick();
        chk("r1_valid1", 128'(valid1), 128'(1'b1));
        chk("r1_idx1", 128'(idx1), 128'(4'd1));
        chk("r1_key1", out1, exp_rk[1]);
        tick();
        chk("r1_done", 128'(done1), 128'(1'b1));
        chk("r1_done_valid", 128'(valid1), 128'(1'b0));
        tick();
        chk("r1_done_pulse", 128'(done1), 128'(1'b0));
        ready1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
